// File: rtl/rst_pkg.sv
// Shared types and defaults for the 48 MHz reset sequencer.
// Imported by the synchroniser and the sequencer top.
package rst_pkg;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_HOLD_CYCLES = 4096;

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_COUNT = 2'd1,
        S_RUN   = 2'd2
    } rst_state_t;

endpackage

// File: rtl/reset_sync_chain.sv
// N-stage async-clear synchroniser.
// Shifts a constant 1 through the chain once clr falls.
module reset_sync_chain
    import rst_pkg::*;
#(
    parameter int STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic clr,
    output logic q
);

    logic [STAGES-1:0] stage;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            stage <= '0;
        end else begin
            stage <= {stage[STAGES-2:0], 1'b1};
        end
    end

    assign q = stage[STAGES-1];

endmodule

// File: rtl/global_reset_seq.sv
// Reset sequencer: async assert, sync release after lock holds.
// Combines the external reset with the PLL lock qualifier.
module global_reset_seq
    import rst_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic rst_in,
    output logic rst,
    output logic rst_n,
    output logic rst_done
);

    localparam int CW = $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic       arst;
    logic       lock_s;
    logic [CW-1:0] count;
    rst_state_t state;

    assign arst = reset | ~rst_in;

    reset_sync_chain #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk(clk),
        .clr(arst),
        .q  (lock_s)
    );

    // The edge that first sees lock_s counts as hold cycle one.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state    <= S_RESET;
            count    <= '0;
            rst      <= 1'b1;
            rst_n    <= 1'b0;
            rst_done <= 1'b0;
        end else begin
            rst_done <= 1'b0;
            unique case (state)
                S_RESET: begin
                    if (lock_s) begin
                        count <= ONE;
                        if (HOLD_CYCLES == 1) begin
                            state    <= S_RUN;
                            rst      <= 1'b0;
                            rst_n    <= 1'b1;
                            rst_done <= 1'b1;
                        end else begin
                            state <= S_COUNT;
                        end
                    end
                end
                S_COUNT: begin
                    count <= count + ONE;
                    if (count == LAST) begin
                        state    <= S_RUN;
                        rst      <= 1'b0;
                        rst_n    <= 1'b1;
                        rst_done <= 1'b1;
                    end
                end
                S_RUN: begin
                    count <= count;
                end
                default: begin
                    state <= S_RESET;
                    count <= '0;
                    rst   <= 1'b1;
                    rst_n <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_global_reset_seq.sv
// Directed bench for global_reset_seq, HOLD=16 and HOLD=1 builds.
// Both instances share stimulus; expectations are hand-derived.
module tb_global_reset_seq;

    logic clk;
    logic reset;
    logic rst_in;
    logic rst_a, rst_n_a, done_a;
    logic rst_b, rst_n_b, done_b;

    int checks;
    int errors;

    global_reset_seq #(
        .SYNC_STAGES(2),
        .HOLD_CYCLES(16)
    ) dut16 (
        .clk     (clk),
        .reset   (reset),
        .rst_in  (rst_in),
        .rst     (rst_a),
        .rst_n   (rst_n_a),
        .rst_done(done_a)
    );

    global_reset_seq #(
        .SYNC_STAGES(2),
        .HOLD_CYCLES(1)
    ) dut1 (
        .clk     (clk),
        .reset   (reset),
        .rst_in  (rst_in),
        .rst     (rst_b),
        .rst_n   (rst_n_b),
        .rst_done(done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_cnt(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_inv();
        chk("rst_n_inv_16", rst_n_a, ~rst_a);
        chk("rst_n_inv_1", rst_n_b, ~rst_b);
    endtask

    task automatic chk_held(input string tag);
        chk({tag, "_rst16"}, rst_a, 1'b1);
        chk({tag, "_rst1"}, rst_b, 1'b1);
        chk({tag, "_done16"}, done_a, 1'b0);
        chk({tag, "_done1"}, done_b, 1'b0);
        chk_inv();
    endtask

    // Edge e counted from the release of arst between edges.
    task automatic run_seq(input string tag, input int n);
        for (int e = 1; e <= n; e++) begin
            @(posedge clk);
            #1;
            chk({tag, "_rst16"}, rst_a, logic'(e < 18));
            chk({tag, "_done16"}, done_a, logic'(e == 18));
            chk({tag, "_rst1"}, rst_b, logic'(e < 3));
            chk({tag, "_done1"}, done_b, logic'(e == 3));
            chk_inv();
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        rst_in = 1'b0;

        #2;
        chk_held("por_async");
        repeat (3) @(posedge clk);
        #1;
        chk_held("por_hold");
        chk_cnt("por_count", int'(dut16.count), 0);

        #4;
        reset  = 1'b0;
        rst_in = 1'b1;
        run_seq("powerup", 21);

        #2;
        rst_in = 1'b0;
        #1;
        chk_held("lockloss_async");
        chk_cnt("lockloss_count", int'(dut16.count), 0);
        #2;
        rst_in = 1'b1;
        run_seq("relock", 20);

        #2;
        rst_in = 1'b0;
        #1;
        rst_in = 1'b1;
        run_seq("precount", 12);
        #2;
        rst_in = 1'b0;
        #1;
        chk_held("glitch_async");
        #2;
        rst_in = 1'b1;
        run_seq("glitch", 20);

        #2;
        reset = 1'b1;
        #1;
        chk_held("extrst_async");
        chk_cnt("extrst_count", int'(dut16.count), 0);
        #10;
        chk_held("extrst_hold");
        reset = 1'b0;
        run_seq("extrst", 20);

        repeat (3) @(posedge clk);
        #1;
        chk("run_stable16", rst_a, 1'b0);
        chk("run_stable1", rst_b, 1'b0);
        chk("run_nodone16", done_a, 1'b0);
        chk_cnt("run_count_held", int'(dut16.count), 16);
        chk_inv();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
